// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-organised, big-endian data memory.
// Optional misalignment trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_we;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;

  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_err;
  logic        r_mem_wr;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_accept;
  logic        w_misalign;
  logic [31:0] w_rdata_next;
  logic [31:0] w_wdata_next;
  logic [31:0] w_addr_next;
  logic        w_err_next;
  logic [4:0]  w_bsh;
  logic [31:0] w_bshifted;
  logic [31:0] w_hshifted;
  logic [31:0] w_load_ext;
  logic [3:0]  w_lane_hit;
  logic [7:0]  w_lane_new [4];
  logic [31:0] w_merged;
  logic        w_unused;

  assign w_accept = req_valid && r_req_ready;
  assign w_unused = &{1'b0, req_addr[31:AW+2]};

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Big-endian: offset 0 lives in the top byte, so shift right by 8*(3-off).
  assign w_bsh      = {~r_off, 3'b000};
  assign w_bshifted = mem_rdata >> w_bsh;
  assign w_hshifted = r_off[1] ? mem_rdata : (mem_rdata >> 16);

  always_comb begin
    w_load_ext = mem_rdata;
    case (r_size)
      2'b00:   w_load_ext = {{24{r_signed & w_bshifted[7]}}, w_bshifted[7:0]};
      2'b01:   w_load_ext = {{16{r_signed & w_hshifted[15]}}, w_hshifted[15:0]};
      default: w_load_ext = mem_rdata;
    endcase
  end

  // Lane gi covers bits [31-8*gi -: 8]; only the addressed lanes take store data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign w_lane_hit[gi] = (r_size == 2'b00) ? (r_off == LANE) : (r_off[1] == LANE[1]);
      assign w_lane_new[gi] = ((r_size == 2'b01) && !LANE[0]) ? r_wdata[15:8] : r_wdata[7:0];
      assign w_merged[31-8*gi -: 8] = w_lane_hit[gi] ? w_lane_new[gi] : mem_rdata[31-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_rdata_next = r_rsp_rdata;
    w_wdata_next = r_mem_wdata;
    w_addr_next  = r_mem_addr;
    w_err_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_addr_next  = {{(32-AW){1'b0}}, req_addr[AW+1:2]};
          w_rdata_next = '0;
          if (w_misalign) begin
            w_state_next = DONE;
            w_err_next   = 1'b1;
          end else if (req_we && req_size[1]) begin
            w_state_next = WR;
            w_wdata_next = req_wdata;
          end else begin
            w_state_next = RD;
          end
        end
      end
      RD: begin
        if (r_we) begin
          w_wdata_next = w_merged;
          w_state_next = WR;
        end else begin
          w_rdata_next = w_load_ext;
          w_state_next = DONE;
        end
      end
      WR:      w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_signed    <= 1'b0;
      r_size      <= 2'b00;
      r_off       <= 2'b00;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_err       <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_next;
      if (r_state == IDLE && w_accept) begin
        r_we     <= req_we;
        r_signed <= req_signed;
        r_size   <= req_size;
        r_off    <= req_addr[1:0];
        r_wdata  <= req_wdata;
      end
      r_req_ready <= (w_state_next == IDLE);
      r_rsp_valid <= (w_state_next == DONE);
      r_mem_wr    <= (w_state_next == WR);
      r_rsp_rdata <= w_rdata_next;
      r_err       <= w_err_next;
      r_mem_addr  <= w_addr_next;
      r_mem_wdata <= w_wdata_next;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign err       = r_err;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-addressed reference model, cycle-level compare.
module tb_load_store_unit;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .err(err), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory seen by the DUT.
  logic [31:0] phys [0:DEPTH-1];
  assign mem_rdata = phys[mem_addr[7:0]];
  always @(posedge clk) if (mem_wr) phys[mem_addr[7:0]] <= mem_wdata;

  // Reference model: byte array, byte 4*i+0 is the most significant byte of word i.
  logic [7:0] mbytes [0:4*DEPTH-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Outstanding transaction expectation
  logic        e_pending = 1'b0;
  logic        e_store, e_trap, e_err;
  int          e_start, e_due, e_idx, e_base, e_n;
  logic [31:0] e_rdata, e_word, e_wdata;
  logic [31:0] last_rdata, last_wdata, last_addr;
  logic        last_err;
  logic [7:0]  wb [4];

  function automatic logic [31:0] model_load(input int idx, input int base, input int n, input logic sgn);
    logic [31:0] v;
    v = 0;
    for (int k = 0; k < n; k++) v = (v << 8) | 32'(mbytes[idx*4 + base + k]);
    if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 1);
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_ready", {31'b0, req_ready}, 32'd1);
      chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset_err", {31'b0, err}, 32'd0);
      chk("reset_mem_wr", {31'b0, mem_wr}, 32'd0);
      chk("reset_mem_addr", mem_addr, 32'd0);
      chk("reset_mem_wdata", mem_wdata, 32'd0);
      chk("reset_rdata", rsp_rdata, 32'd0);
      e_pending = 1'b0;
    end else begin
      logic exp_wr, exp_rsp;
      chk("req_ready", {31'b0, req_ready}, {31'b0, !e_pending});
      exp_wr  = e_pending && e_store && !e_trap && (cyc == e_due - 1);
      exp_rsp = e_pending && (cyc == e_due);
      chk("mem_wr", {31'b0, mem_wr}, {31'b0, exp_wr});
      if (e_pending && !e_trap && cyc > e_start && cyc < e_due) begin
        chk("mem_addr", mem_addr, 32'(e_idx));
        last_addr = mem_addr;
      end
      if (exp_wr) begin
        chk("mem_wdata", mem_wdata, e_word);
        last_wdata = mem_wdata;
        for (int k = 0; k < e_n; k++)
          mbytes[e_idx*4 + e_base + k] = 8'(e_wdata >> (8*(e_n-1-k)));
      end
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rsp});
      chk("err", {31'b0, err}, {31'b0, exp_rsp && e_err});
      if (exp_rsp) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        last_rdata = rsp_rdata;
        last_err   = err;
        e_pending  = 1'b0;
      end
      if (req_valid && req_ready && !e_pending) begin
        int off;
        off     = int'(req_addr[1:0]);
        e_n     = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
        e_base  = (e_n == 1) ? off : (e_n == 2) ? (off & 2) : 0;
        e_idx   = int'((req_addr >> 2) % DEPTH);
        e_store = req_we;
        e_wdata = req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
        e_trap  = (e_n == 2 && (off % 2) == 1) || (e_n == 4 && off != 0);
`else
        e_trap  = 1'b0;
`endif
        e_err   = e_trap;
        e_start = cyc;
        e_due   = cyc + (e_trap ? 1 : (!req_we || e_n == 4) ? 2 : 3);
        e_rdata = (e_trap || req_we) ? 32'd0 : model_load(e_idx, e_base, e_n, req_signed);
        for (int k = 0; k < 4; k++) wb[k] = mbytes[e_idx*4 + k];
        for (int k = 0; k < e_n; k++) wb[e_base + k] = 8'(req_wdata >> (8*(e_n-1-k)));
        e_word  = {wb[0], wb[1], wb[2], wb[3]};
        e_pending = 1'b1;
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    bit acc;
    acc = 0;
    @(posedge clk); #1;
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1;
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: request at 0x%08h not accepted within 20 cycles", addr);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Keep valid asserted with scrambled fields; the busy unit must ignore them.
    for (int h = 0; h < hold; h++) begin
      req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      if (!e_pending) return;
    end
    n_checks++; n_fail++;
    $display("FAIL rsp_timeout: no response for request at 0x%08h", addr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) phys[i] = '0;
    for (int i = 0; i < 4*DEPTH; i++) mbytes[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_req(1, 2'd2, 0, 32'h10, 32'h11223344, 0);
    chk("lit_sw_wdata", last_wdata, 32'h11223344);
    chk("lit_sw_addr", last_addr, 32'd4);
    do_req(0, 2'd2, 0, 32'h10, 32'h0, 0);
    chk("lit_lw", last_rdata, 32'h11223344);
    do_req(0, 2'd0, 1, 32'h10, 32'h0, 0);
    chk("lit_lb", last_rdata, 32'h00000011);
    do_req(0, 2'd0, 0, 32'h13, 32'h0, 0);
    chk("lit_lbu", last_rdata, 32'h00000044);
    do_req(1, 2'd2, 0, 32'h20, 32'h80FF0000, 0);
    do_req(0, 2'd0, 1, 32'h20, 32'h0, 0);
    chk("lit_lb_neg", last_rdata, 32'hFFFFFF80);
    do_req(1, 2'd0, 0, 32'h11, 32'h000000AA, 0);
    chk("lit_sb_merge", last_wdata, 32'h11AA3344);
    do_req(1, 2'd1, 0, 32'h12, 32'h00008000, 0);
    chk("lit_sh_merge", last_wdata, 32'h11AA8000);
    do_req(0, 2'd1, 1, 32'h12, 32'h0, 0);
    chk("lit_lh_neg", last_rdata, 32'hFFFF8000);

    // Reset while a byte store sits in its read phase.
    @(posedge clk); #1;
    req_we = 1; req_size = 2'd0; req_signed = 0; req_addr = 32'h10; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("async_rst_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    do_req(0, 2'd2, 0, 32'h10, 32'h0, 0);
    chk("lit_after_rst", last_rdata, 32'h11AA8000);

    do_req(0, 2'd2, 0, 32'h10, 32'h0, 2);
    chk("lit_hold_lw", last_rdata, 32'h11AA8000);
    do_req(0, 2'd2, 0, 32'h400, 32'h0, 0);
    chk("lit_wrap_addr", last_addr, 32'd0);

    do_req(0, 2'd2, 0, 32'h12, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lit_misalign_rdata", last_rdata, 32'h0);
    chk("lit_misalign_err", {31'b0, last_err}, 32'd1);
`else
    chk("lit_misalign_rdata", last_rdata, 32'h11AA8000);
    chk("lit_misalign_err", {31'b0, last_err}, 32'd0);
`endif

    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
             ($urandom_range(0, 4) == 0) ? 2 : 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
